// File: rtl/spmv_row_collector.sv
// Collects completed SpMV output rows, tags them with a row index and buffers them in a FIFO
// drained over ready/valid. Optional signed 32-bit column saturation: SPMV_COLLECT_SAT_EN.
module spmv_row_collector #(
  parameter int unsigned N_ROWS = 560,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = 4,
  parameter int unsigned RW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_mul_valid,
  input  logic          i_mul_zeros,
  input  logic [63:0]   i_mul_data1,
  input  logic [63:0]   i_mul_data2,
  input  logic          i_mul_done,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [RW-1:0] o_out_row,
  output logic [63:0]   o_out_data1,
  output logic [63:0]   o_out_data2,
  output logic          o_busy,
  output logic          o_all_done,
  output logic          o_row_err,
  output logic          o_ovf,
  output logic          o_sat_flag
);

  localparam int unsigned CW = $clog2(N_ROWS + 1);

  typedef enum logic [1:0] {StIdle, StCollect, StDrain, StDone} state_e;

  state_e        r_state;
  logic          r_busy, r_all_done, r_row_err, r_ovf, r_sat;
  logic [CW-1:0] r_row_cnt;
  logic          r_cap_vld;
  logic [RW-1:0] r_cap_row;
  logic [63:0]   r_cap_d1, r_cap_d2;
  logic [AW:0]   r_wptr, r_rptr;
  logic [RW-1:0] r_mem_row [DEPTH];
  logic [63:0]   r_mem_d1  [DEPTH];
  logic [63:0]   r_mem_d2  [DEPTH];

  logic        w_empty, w_full, w_pop, w_push, w_evt, w_take, w_cnt_max, w_clip;
  logic [63:0] w_d1_raw, w_d2_raw, w_d1, w_d2;

  assign w_empty   = (r_wptr == r_rptr);
  assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop     = !w_empty && i_out_ready;
  // A full FIFO still accepts the capture entry when the head leaves this cycle.
  assign w_push    = r_cap_vld && (!w_full || w_pop);
  assign w_evt     = i_mul_valid || i_mul_zeros;
  assign w_cnt_max = (r_row_cnt == CW'(N_ROWS));
  assign w_take    = (r_state == StCollect) && w_evt && !i_start && !w_cnt_max;
  assign w_d1_raw  = i_mul_valid ? i_mul_data1 : 64'd0;
  assign w_d2_raw  = i_mul_valid ? i_mul_data2 : 64'd0;

`ifdef SPMV_COLLECT_SAT_EN
  function automatic logic [63:0] sat32(input logic [63:0] v);
    if (v[63:31] == {33{v[63]}}) return v;
    return v[63] ? {{33{1'b1}}, 31'd0} : {33'd0, {31{1'b1}}};
  endfunction

  assign w_d1   = sat32(w_d1_raw);
  assign w_d2   = sat32(w_d2_raw);
  assign w_clip = w_take && ((w_d1 != w_d1_raw) || (w_d2 != w_d2_raw));
`else
  assign w_d1   = w_d1_raw;
  assign w_d2   = w_d2_raw;
  assign w_clip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_all_done <= 1'b0;
      r_row_err  <= 1'b0;
      r_ovf      <= 1'b0;
      r_sat      <= 1'b0;
      r_row_cnt  <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_row  <= '0;
      r_cap_d1   <= '0;
      r_cap_d2   <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else if (i_start) begin
      r_state    <= StCollect;
      r_busy     <= 1'b1;
      r_all_done <= 1'b0;
      r_row_err  <= 1'b0;
      r_ovf      <= 1'b0;
      r_sat      <= 1'b0;
      r_row_cnt  <= '0;
      r_cap_vld  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
    end else begin
      r_cap_vld <= w_take;
      if (w_take) begin
        r_cap_row <= RW'(r_row_cnt);
        r_cap_d1  <= w_d1;
        r_cap_d2  <= w_d2;
        r_row_cnt <= r_row_cnt + CW'(1);
      end
      if (w_clip) r_sat <= 1'b1;
      if (w_push) r_wptr <= r_wptr + (AW + 1)'(1);
      if (w_pop) r_rptr <= r_rptr + (AW + 1)'(1);
      if (r_cap_vld && !w_push) r_ovf <= 1'b1;

      case (r_state)
        StCollect: begin
          if (w_evt && w_cnt_max) r_row_err <= 1'b1;
          if (i_mul_done) r_state <= StDrain;
        end
        StDrain: begin
          if (w_evt) r_row_err <= 1'b1;
          if (w_empty && !r_cap_vld) begin
            r_state    <= StDone;
            r_busy     <= 1'b0;
            r_all_done <= 1'b1;
            if (!w_cnt_max) r_row_err <= 1'b1;
          end
        end
        StDone: begin
          if (w_evt) r_row_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_row[r_wptr[AW-1:0]] <= r_cap_row;
      r_mem_d1[r_wptr[AW-1:0]]  <= r_cap_d1;
      r_mem_d2[r_wptr[AW-1:0]]  <= r_cap_d2;
    end
  end

  // Head fields read as zero while the FIFO is empty so no stale row is ever presented.
  assign o_out_valid = !w_empty;
  assign o_out_row   = w_empty ? '0 : r_mem_row[r_rptr[AW-1:0]];
  assign o_out_data1 = w_empty ? '0 : r_mem_d1[r_rptr[AW-1:0]];
  assign o_out_data2 = w_empty ? '0 : r_mem_d2[r_rptr[AW-1:0]];
  assign o_busy      = r_busy;
  assign o_all_done  = r_all_done;
  assign o_row_err   = r_row_err;
  assign o_ovf       = r_ovf;
  assign o_sat_flag  = r_sat;

endmodule

// File: tb/tb_spmv_row_collector.sv
// Self-checking bench for spmv_row_collector: queue-based reference model compared every cycle,
// plus literal expectations for the directed scenarios.
module tb_spmv_row_collector;

  localparam int N     = 20;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int RW    = 10;

  logic          clk, rst;
  logic          i_start, i_mul_valid, i_mul_zeros, i_mul_done, i_out_ready;
  logic [63:0]   i_mul_data1, i_mul_data2;
  logic          o_out_valid, o_busy, o_all_done, o_row_err, o_ovf, o_sat_flag;
  logic [RW-1:0] o_out_row;
  logic [63:0]   o_out_data1, o_out_data2;

  spmv_row_collector #(.N_ROWS(N), .DEPTH(DEPTH), .AW(AW), .RW(RW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_mul_valid(i_mul_valid),
    .i_mul_zeros(i_mul_zeros), .i_mul_data1(i_mul_data1), .i_mul_data2(i_mul_data2),
    .i_mul_done(i_mul_done), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_row(o_out_row), .o_out_data1(o_out_data1), .o_out_data2(o_out_data2),
    .o_busy(o_busy), .o_all_done(o_all_done), .o_row_err(o_row_err), .o_ovf(o_ovf),
    .o_sat_flag(o_sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [RW-1:0] row;
    logic [63:0]   d1;
    logic [63:0]   d2;
  } ent_t;

  ent_t m_fifo[$];
  ent_t m_pipe;
  bit   m_pipe_v;
  int   m_state;  // 0 idle, 1 collect, 2 drain, 3 done
  int   m_cnt;
  bit   m_err, m_ovf, m_sat;

  function automatic logic [63:0] msat(input logic [63:0] v);
`ifdef SPMV_COLLECT_SAT_EN
    longint s;
    s = signed'(v);
    if (s > 64'sd2147483647) return 64'h0000_0000_7FFF_FFFF;
    if (s < -64'sd2147483648) return 64'hFFFF_FFFF_8000_0000;
`endif
    return v;
  endfunction

  always @(posedge clk) begin : model
    bit   evt, idle_pipe;
    ent_t e;
    if (!rst || i_start) begin
      m_state  = (!rst) ? 0 : 1;
      m_cnt    = 0;
      m_fifo.delete();
      m_pipe_v = 0;
      m_err    = 0;
      m_ovf    = 0;
      m_sat    = 0;
    end else begin
      idle_pipe = (m_fifo.size() == 0) && !m_pipe_v;
      if (m_fifo.size() > 0 && i_out_ready) void'(m_fifo.pop_front());
      if (m_pipe_v) begin
        if (m_fifo.size() < DEPTH) m_fifo.push_back(m_pipe);
        else m_ovf = 1;
      end
      m_pipe_v = 0;
      evt = i_mul_valid || i_mul_zeros;
      case (m_state)
        1: begin
          if (evt) begin
            if (m_cnt == N) m_err = 1;
            else begin
              e.row = RW'(m_cnt);
              e.d1  = i_mul_valid ? msat(i_mul_data1) : 64'd0;
              e.d2  = i_mul_valid ? msat(i_mul_data2) : 64'd0;
              if (i_mul_valid && (e.d1 != i_mul_data1 || e.d2 != i_mul_data2)) m_sat = 1;
              m_pipe   = e;
              m_pipe_v = 1;
              m_cnt++;
            end
          end
          if (i_mul_done) m_state = 2;
        end
        2: begin
          if (evt) m_err = 1;
          if (idle_pipe) begin
            m_state = 3;
            if (m_cnt != N) m_err = 1;
          end
        end
        3: if (evt) m_err = 1;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : compare
    bit v;
    v = m_fifo.size() > 0;
    chk1("out_valid", o_out_valid, v);
    chk64("out_row", 64'(o_out_row), v ? 64'(m_fifo[0].row) : 64'd0);
    chk64("out_data1", o_out_data1, v ? m_fifo[0].d1 : 64'd0);
    chk64("out_data2", o_out_data2, v ? m_fifo[0].d2 : 64'd0);
    chk1("busy", o_busy, m_state == 1 || m_state == 2);
    chk1("all_done", o_all_done, m_state == 3);
    chk1("row_err", o_row_err, m_err);
    chk1("ovf", o_ovf, m_ovf);
    chk1("sat_flag", o_sat_flag, m_sat);
  end

  // Log of rows the consumer actually accepted, for the literal checks.
  ent_t pop_log[$];
  always @(posedge clk) begin
    ent_t e;
    if (rst && !i_start && o_out_valid && i_out_ready) begin
      e.row = o_out_row;
      e.d1  = o_out_data1;
      e.d2  = o_out_data2;
      pop_log.push_back(e);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input logic st, input logic v, input logic z, input logic dn,
                      input logic [63:0] a, input logic [63:0] b);
    i_start = st; i_mul_valid = v; i_mul_zeros = z; i_mul_done = dn;
    i_mul_data1 = a; i_mul_data2 = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 64'd0, 64'd0);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k;
    k = 0;
    i_start = 0; i_mul_valid = 0; i_mul_zeros = 0; i_mul_done = 0;
    while (!o_all_done && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk1(name, o_all_done, 1'b1);
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    int s;
    case ($urandom_range(0, 2))
      0: begin
        s = int'($urandom_range(0, 2000)) - 1000;
        v = {{32{s[31]}}, s};
      end
      1: v = {$urandom, $urandom};
      default: begin
        v = 64'h7FFF_FFFC + 64'($urandom_range(0, 7));
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst = 0; i_out_ready = 0;
    i_start = 0; i_mul_valid = 0; i_mul_zeros = 0; i_mul_done = 0;
    i_mul_data1 = 0; i_mul_data2 = 0;
    repeat (2) @(negedge clk);
    chk1("reset_out_valid", o_out_valid, 1'b0);
    chk1("reset_busy", o_busy, 1'b0);
    chk64("reset_out_row", 64'(o_out_row), 64'd0);
    rst = 1;
    idle(2);

    // Normal run: literal rows first, then random rows up to N.
    i_out_ready = 1;
    step(1, 0, 0, 0, 0, 0);
    pop_log.delete();
    step(0, 1, 0, 0, 64'd5, -64'sd3);
    step(0, 0, 1, 0, 64'd123, 64'd456);
    step(0, 1, 0, 0, 64'd7, 64'd8);
    step(0, 1, 0, 0, 64'd1, 64'd2);
    step(0, 1, 1, 0, 64'd9, 64'd10);
    for (int i = 5; i < N; i++) begin
      step(0, 1, 0, 0, rnd64(), rnd64());
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    step(0, 0, 0, 1, 0, 0);
    wait_done("normal_done", 100);
    chk1("normal_row_err", o_row_err, 1'b0);
    chk64("normal_count", 64'(pop_log.size()), 64'(N));
    if (pop_log.size() >= 5) begin
      chk64("r0_d1", pop_log[0].d1, 64'd5);
      chk64("r0_d2", pop_log[0].d2, 64'hFFFF_FFFF_FFFF_FFFD);
      chk64("r1_d1", pop_log[1].d1, 64'd0);
      chk64("r1_row", 64'(pop_log[1].row), 64'd1);
      chk64("r2_d2", pop_log[2].d2, 64'd8);
      chk64("r3_d1", pop_log[3].d1, 64'd1);
      chk64("both_d1", pop_log[4].d1, 64'd9);
    end

    // Backpressure: 17 events into a 16-entry FIFO.
    i_out_ready = 0;
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 0, 0, 64'(i + 100), 64'(i));
    idle(3);
    chk1("bp_ovf", o_ovf, 1'b1);
    chk64("bp_head_row", 64'(o_out_row), 64'd0);
    pop_log.delete();
    i_out_ready = 1;
    idle(20);
    chk64("bp_count", 64'(pop_log.size()), 64'd16);
    foreach (pop_log[i]) chk64("bp_row_order", 64'(pop_log[i].row), 64'(i));
    step(0, 0, 0, 1, 0, 0);
    wait_done("bp_done", 50);

    // Too few rows.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, rnd64(), rnd64());
    step(0, 0, 0, 1, 0, 0);
    wait_done("short_done", 50);
    chk1("short_row_err", o_row_err, 1'b1);

    // One row too many.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, 0, 1, 0, 0, 0);
    chk1("excess_pre_err", o_row_err, 1'b0);
    step(0, 1, 0, 0, 64'd77, 64'd77);
    chk1("excess_err", o_row_err, 1'b1);
    step(0, 0, 0, 1, 0, 0);
    wait_done("excess_done", 50);

    // Saturation of a just-over-range column.
    i_out_ready = 0;
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 64'h0000_0001_0000_0000, 64'd3);
    idle(3);
`ifdef SPMV_COLLECT_SAT_EN
    chk64("sat_d1", o_out_data1, 64'h0000_0000_7FFF_FFFF);
    chk1("sat_flag_lit", o_sat_flag, 1'b1);
`else
    chk64("sat_d1", o_out_data1, 64'h0000_0001_0000_0000);
    chk1("sat_flag_lit", o_sat_flag, 1'b0);
`endif

    // Reset mid-run with entries buffered.
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 64'(i), 64'(i));
    idle(2);
    rst = 0;
    idle(1);
    rst = 1;
    chk1("rst_out_valid", o_out_valid, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 64'd55, 64'd55);
    idle(2);
    chk1("idle_ignored", o_out_valid, 1'b0);
    chk1("idle_no_err", o_row_err, 1'b0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 64'd11, 64'd22);
    idle(3);
    chk64("after_rst_row", 64'(o_out_row), 64'd0);
    chk64("after_rst_d1", o_out_data1, 64'd11);

    // Random runs with varying backpressure and late events during drain.
    for (int r = 0; r < 6; r++) begin
      int k;
      step(1, 0, 0, 0, 0, 0);
      for (int c = 0; c < 60; c++) begin
        logic v, z;
        i_out_ready = ($urandom_range(0, 5) < r);
        v = ($urandom_range(0, 9) < 5);
        z = ($urandom_range(0, 9) < 2);
        step(0, v, z, 0, rnd64(), rnd64());
      end
      step(0, 0, 0, 1, 0, 0);
      k = 0;
      while (!o_all_done && k < 300) begin
        i_out_ready = ($urandom_range(0, 1) == 1);
        step(0, ($urandom_range(0, 9) == 0), 0, 0, rnd64(), rnd64());
        k++;
      end
      chk1("rand_done", o_all_done, 1'b1);
      step(0, 1, 0, 0, 64'd1, 64'd1);
      idle(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
